// File: rtl/bsg_async_fifo_w_ctrl_pkg.sv
// Shared types and helpers for the async FIFO write-side controller.
// Flush FSM encoding and the pointer-width helper.
package bsg_async_fifo_w_ctrl_pkg;

  typedef enum logic [1:0] {
    eRun   = 2'd0,
    eDrain = 2'd1,
    eDone  = 2'd2
  } state_e;

  // One extra wrap bit on top of log2(depth).
  function automatic int unsigned ptr_width(input int unsigned lg_size);
    return lg_size + 1;
  endfunction

endpackage

// File: rtl/bsg_async_fifo_gray_to_binary.sv
// Combinational gray-to-binary converter: bit i is the XOR of gray bits [width_p-1:i].
module bsg_async_fifo_gray_to_binary #(
  parameter int unsigned width_p = 5
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  always_comb begin
    binary_o = '0;
    for (int unsigned i = 0; i < width_p; i++) begin
      binary_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/bsg_async_fifo_w_ctrl.sv
// Write-domain controller for the gray-pointer async FIFO: handshake, full detect, flush sequencing.
// Define BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN to add the registered occupancy and almost_full_o.
module bsg_async_fifo_w_ctrl
  import bsg_async_fifo_w_ctrl_pkg::*;
#(
  parameter int unsigned lg_size_p            = 4,
  parameter int unsigned almost_full_thresh_p = 12,
  localparam int unsigned ptr_w               = ptr_width(lg_size_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             v_i,
  output logic             ready_o,
  output logic             w_inc_o,
  input  logic [ptr_w-1:0] w_ptr_binary_i,
  input  logic [ptr_w-1:0] w_ptr_gray_i,
  input  logic [ptr_w-1:0] r_ptr_gray_rsync_i,
  input  logic             flush_i,
  output logic             flush_busy_o,
  output logic             flush_done_o
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
  ,
  output logic             almost_full_o
`endif
);

  state_e state_r;
  logic   full, empty;

  // Full when the pointers differ only in the top two gray bits (one lap apart).
  assign full  = (w_ptr_gray_i == {~r_ptr_gray_rsync_i[ptr_w-1 -: 2], r_ptr_gray_rsync_i[ptr_w-3:0]});
  assign empty = (w_ptr_gray_i == r_ptr_gray_rsync_i);

  assign ready_o      = (state_r == eRun) & ~full;
  assign w_inc_o      = v_i & ready_o;
  assign flush_busy_o = (state_r != eRun);
  assign flush_done_o = (state_r == eDone);

`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
  localparam logic [ptr_w-1:0] af_thresh = ptr_w'(almost_full_thresh_p);

  if (almost_full_thresh_p > (2 ** lg_size_p)) begin : g_bad_thresh
    $error("almost_full_thresh_p exceeds FIFO depth");
  end

  logic [ptr_w-1:0] r_ptr_binary;
  logic [ptr_w-1:0] occ_r;

  bsg_async_fifo_gray_to_binary #(
    .width_p(ptr_w)
  ) r_g2b (
    .gray_i  (r_ptr_gray_rsync_i),
    .binary_o(r_ptr_binary)
  );

  assign almost_full_o = (occ_r >= af_thresh);
`else
  localparam int unsigned unused_thresh = almost_full_thresh_p;
  logic unused_w_ptr_binary;
  assign unused_w_ptr_binary = ^w_ptr_binary_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eRun;
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
      occ_r   <= '0;
`endif
    end else begin
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
      occ_r <= w_ptr_binary_i - r_ptr_binary;
`endif
      unique case (state_r)
        eRun:    if (flush_i) state_r <= eDrain;
        // empty is evaluated on the live pointers, so a write accepted the
        // cycle the flush was taken is counted before the drain can finish.
        eDrain:  if (empty) state_r <= eDone;
        eDone:   state_r <= eRun;
        default: state_r <= eRun;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_async_fifo_w_ctrl.sv
// Directed bench for bsg_async_fifo_w_ctrl with a behavioural pointer block model.
// Build with BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN to also exercise almost_full_o.
module tb_bsg_async_fifo_w_ctrl;

  localparam int unsigned PW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] rptr = '0;
  logic          ready, w_inc, busy, done;
  logic [PW-1:0] w_bin, w_gray;
  int            n_inc;
  int            n_checks = 0;
  int            n_err = 0;
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
  logic          af;
`endif

  always #5 clk = ~clk;

  bsg_async_fifo_w_ctrl #(
    .lg_size_p(4),
    .almost_full_thresh_p(12)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .v_i               (v),
    .ready_o           (ready),
    .w_inc_o           (w_inc),
    .w_ptr_binary_i    (w_bin),
    .w_ptr_gray_i      (w_gray),
    .r_ptr_gray_rsync_i(rptr),
    .flush_i           (flush),
    .flush_busy_o      (busy),
    .flush_done_o      (done)
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
    ,
    .almost_full_o     (af)
`endif
  );

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Pointer block model: binary and gray write pointers, both registered.
  always @(posedge clk) begin
    if (reset) begin
      w_bin  <= '0;
      w_gray <= '0;
      n_inc  <= 0;
    end else if (w_inc) begin
      w_bin  <= w_bin + 5'd1;
      w_gray <= b2g(w_bin + 5'd1);
      n_inc  <= n_inc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic dropped;

  initial begin
    // 1: fill from reset with the reader stalled at 0
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
    chk("rst_af", af, 0);
`endif
    v = 1'b1;
    #1;
    for (int i = 0; i < 15; i++) tick();
    chk("fill15_ready", ready, 1);
    tick();
    chk("fill16_ready", ready, 0);
    chk("fill16_winc", w_inc, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("fill_count", n_inc, 16);
    chk("fill_hold_ready", ready, 0);

    // 2: reader frees one slot
    rptr = 5'b00001;
    #1;
    chk("free1_ready", ready, 1);
    tick();
    chk("refull_ready", ready, 0);
    chk("refull_count", n_inc, 17);

    // 3: reader trails by two entries across a pointer wrap
    rptr = b2g(5'd15);
    #1;
    dropped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      rptr = b2g(w_bin - 5'd2);
      #1;
      if (!ready) dropped = 1'b1;
    end
    chk("track_no_drop", dropped, 0);
    chk("track_count", n_inc, 57);

    // 4: flush with three entries outstanding (w=25)
    v = 1'b0;
    rptr = b2g(5'd22);
    flush = 1'b1;
    #1;
    chk("flush_req_ready", ready, 1);
    chk("flush_req_busy", busy, 0);
    tick();
    flush = 1'b0;
    chk("drain_ready", ready, 0);
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    rptr = b2g(5'd23);
    tick();
    rptr = b2g(5'd24);
    tick();
    chk("drain2_done", done, 0);
    rptr = b2g(5'd25);
    #1;
    chk("drain_empty_done", done, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("done_ready", ready, 0);
    chk("done_busy", busy, 1);
    tick();
    chk("post_done", done, 0);
    chk("post_ready", ready, 1);
    chk("post_busy", busy, 0);

    // 5: write coincident with flush is accepted, then drained
    v = 1'b1;
    flush = 1'b1;
    #1;
    chk("cowrite_winc", w_inc, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("cowrite_blocked", w_inc, 0);
    chk("cowrite_count", n_inc, 58);
    tick();
    chk("cowrite_not_done", done, 0);
    rptr = b2g(5'd26);
    tick();
    chk("cowrite_done", done, 1);
    chk("cowrite_done_winc", w_inc, 0);
    tick();
    chk("cowrite_post_done", done, 0);
    chk("cowrite_post_ready", ready, 1);
    v = 1'b0;

    // 6: twelve writes from reset, then reset in the middle of a drain
    reset = 1'b1;
    rptr = '0;
    tick();
    reset = 1'b0;
    v = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) tick();
    v = 1'b0;
    #1;
    chk("af_count", n_inc, 12);
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
    chk("af_lag", af, 0);
    tick();
    chk("af_set", af, 1);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rdrain_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rdrain_ready", ready, 1);
    chk("rdrain_busy_clr", busy, 0);
    chk("rdrain_done", done, 0);
`ifdef BSG_ASYNC_FIFO_W_CTRL_ALMOST_FULL_EN
    chk("rdrain_af", af, 0);
`endif
    tick();
    chk("rdrain_no_pulse", done, 0);
    tick();
    chk("rdrain_no_pulse2", done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
